stream_fifo: RTL



---
 rtl/nla_mem_pkg.sv | 27 ++
 rtl/stream_fifo_sdp_bram.sv | 31 +++
 rtl/stream_fifo.sv | 95 +++++++++
 3 files changed

// File: rtl/nla_mem_pkg.sv
// Shared memory-block defaults and the FIFO status-flag helper.
package nla_mem_pkg;

   localparam int          DEF_DATA_W    = 32;
   localparam int          DEF_ADDR_W    = 10;
   localparam int          DEF_AEMPTY_TH = 4;
   // Default in-band start marker: a NaN bit pattern never produced by real samples
   localparam logic [31:0] DEF_MARKER    = 32'h7F90_0000;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } fifo_flags_t;

   function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                              input int afull_th, input int aempty_th);
      fifo_flags_t f;
      f.full   = (cnt == depth);
      f.empty  = (cnt == 0);
      f.afull  = (cnt >= afull_th);
      f.aempty = (cnt <= aempty_th);
      return f;
   endfunction

endpackage

// File: rtl/stream_fifo_sdp_bram.sv
// Simple dual-port RAM: one clock, write port A, registered read port B.
module sdp_bram
   import nla_mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Array is never reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Output register holds its value between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO controller over a block-RAM store, with in-band marker stripping.
module stream_fifo
   import nla_mem_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                AFULL_TH  = (2**ADDR_W) - 4,
   parameter int                AEMPTY_TH = DEF_AEMPTY_TH,
   parameter bit                MARKER_EN = 1'b1,
   parameter logic [DATA_W-1:0] MARKER    = DATA_W'(DEF_MARKER)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              afull_o,
   output logic              aempty_o,
   output logic [ADDR_W:0]   count_o,
   output logic              marker_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int                DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic              is_marker;
   logic              wr_acc;
   logic              rd_acc;
   fifo_flags_t       flags_nxt;

   // Markers are dropped before the full check, so they pulse even when full
   always_comb begin
      is_marker = MARKER_EN && wr_en_i && (data_i == MARKER);
      wr_acc    = wr_en_i && !full_o && !is_marker;
      rd_acc    = rd_en_i && !empty_o;
      count_nxt = count_o;
      if (wr_acc && !rd_acc)      count_nxt = count_o + CNT_ONE;
      else if (rd_acc && !wr_acc) count_nxt = count_o - CNT_ONE;
      flags_nxt = calc_flags(int'(count_nxt), DEPTH, AFULL_TH, AEMPTY_TH);
   end

   // Flags come from the next count so they line up with count_o
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_o     <= '0;
         full_o      <= 1'b0;
         empty_o     <= 1'b1;
         afull_o     <= 1'b0;
         aempty_o    <= 1'b1;
         valid_o     <= 1'b0;
         marker_o    <= 1'b0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         count_o     <= count_nxt;
         full_o      <= flags_nxt.full;
         empty_o     <= flags_nxt.empty;
         afull_o     <= flags_nxt.afull;
         aempty_o    <= flags_nxt.aempty;
         valid_o     <= rd_acc;
         marker_o    <= is_marker;
         overflow_o  <= overflow_o  | (wr_en_i && full_o && !is_marker);
         underflow_o <= underflow_o | (rd_en_i && empty_o);
      end
   end

   sdp_bram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_i),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (data_o)
   );

endmodule
